// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state type and the size/direction legality helper.
package riscv_lsu_pkg;

  // funct3 encodings of the access size
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_WB  = 2'd1,
    STORE_WR = 2'd2
  } lsu_state_t;

  // Unsigned sizes exist only for loads; everything else is undefined.
  function automatic logic size_legal(input logic we, input logic [2:0] size);
    logic ok;
    ok = 1'b0;
    case (size)
      LDST_B, LDST_H, LDST_W: ok = 1'b1;
      LDST_BU, LDST_HU:       ok = !we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
//
// Handshake: the core raises lsu_req_i with all lsu_* inputs valid and keeps
// them stable; the request completes in the cycle where lsu_req_i=1 and
// lsu_stall_req_o=0. lsu_data_o/lsu_fault_o are meaningful only in that
// completion cycle. data_rdata_i must be combinational from data_addr_o and
// memory writes data_wdata_o on the clock edge where data_we_o is high.
interface riscv_lsu_if;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_fault_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_we_o;
  logic [31:0] data_rdata_i;

  // LSU side
  modport slave (
    input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i, data_rdata_i,
    output lsu_data_o, lsu_stall_req_o, lsu_fault_o, data_addr_o, data_wdata_o, data_we_o
  );

  // Core plus memory side
  modport master (
    output lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i, data_rdata_i,
    input  lsu_data_o, lsu_stall_req_o, lsu_fault_o, data_addr_o, data_wdata_o, data_we_o
  );
endinterface

// File: rtl/riscv_lsu_byte_lane.sv
// Combinational byte-lane logic: load lane extract with sign/zero extension,
// store lane merge into a read word, and the misalignment check.
module lsu_byte_lane
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend by access type
  always_comb begin
    shifted   = word >> {offset, 3'b000};
    load_data = '0;
    case (size)
      LDST_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      LDST_BU: load_data = {24'h0, shifted[7:0]};
      LDST_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      LDST_HU: load_data = {16'h0, shifted[15:0]};
      LDST_W:  load_data = word;
      default: load_data = '0;
    endcase
  end

  // Replace only the addressed lane(s); the other bytes keep the read value
  always_comb begin
    merge_data = word;
    case (size)
      LDST_B:  merge_data[{offset, 3'b000} +: 8] = store_data[7:0];
      LDST_H:  merge_data[{offset[1], 4'b0000} +: 16] = store_data;
      default: merge_data = word;
    endcase
  end

  // Halves need an even offset, words a zero offset
  always_comb begin
    misaligned = ((size[1:0] == 2'b01) && offset[0]) ||
                 ((size[1:0] == 2'b10) && (offset != 2'b00));
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: turns byte/half/word requests into word accesses,
// uses read-modify-write for sub-word stores, and stalls the core meanwhile.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h88000000,
  parameter int          SIZE_BYTES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  riscv_lsu_if.slave    bus,
  output lsu_state_t    state_o
);

  lsu_state_t  state, state_next;
  logic [31:0] cap_word;
  logic        cap_en;
  logic [31:0] win_off;
  logic        in_window;
  logic        misaligned;
  logic        legal;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  logic [31:0] data_o;
  logic        stall;
  logic        fault;
  logic        we;
  logic [31:0] wdata;

  lsu_byte_lane u_lane (
    .size       (bus.lsu_size_i),
    .offset     (bus.lsu_addr_i[1:0]),
    .word       (cap_word),
    .store_data (bus.lsu_data_i[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data),
    .misaligned (misaligned)
  );

  // Unsigned offset compare also rejects addresses below the window (wraps high)
  always_comb begin
    win_off   = bus.lsu_addr_i - BASE_ADDR;
    in_window = (win_off < 32'(SIZE_BYTES));
    legal     = size_legal(bus.lsu_we_i, bus.lsu_size_i) && !misaligned && in_window;
  end

  // State register; reset discards any pending read-modify-write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Capture the memory word read in the first cycle of a load or sub-word store
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       cap_word <= '0;
    else if (cap_en) cap_word <= bus.data_rdata_i;
  end

  // Next state and all handshake/memory outputs; everything is quiet in reset
  always_comb begin
    state_next = state;
    cap_en     = 1'b0;
    data_o     = '0;
    stall      = 1'b0;
    fault      = 1'b0;
    we         = 1'b0;
    wdata      = '0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (bus.lsu_req_i) begin
            if (!legal) begin
              fault = 1'b1;
            end else if (!bus.lsu_we_i) begin
              stall      = 1'b1;
              cap_en     = 1'b1;
              state_next = LOAD_WB;
            end else if (bus.lsu_size_i == LDST_W) begin
              we    = 1'b1;
              wdata = bus.lsu_data_i;
            end else begin
              stall      = 1'b1;
              cap_en     = 1'b1;
              state_next = STORE_WR;
            end
          end
        end
        LOAD_WB: begin
          state_next = IDLE;
          if (bus.lsu_req_i) data_o = load_data;
        end
        STORE_WR: begin
          state_next = IDLE;
          if (bus.lsu_req_i) begin
            we    = 1'b1;
            wdata = merge_data;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.data_addr_o     = bus.lsu_req_i ? {bus.lsu_addr_i[31:2], 2'b00} : 32'h0;
  assign bus.lsu_data_o      = data_o;
  assign bus.lsu_stall_req_o = stall;
  assign bus.lsu_fault_o     = fault;
  assign bus.data_we_o       = we;
  assign bus.data_wdata_o    = wdata;
  assign state_o             = state;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: word memory in the bench, byte-array reference model,
// expected-response queue drained by a monitor at every completion.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  localparam logic [31:0] BASE = 32'h88000000;
  localparam int          SIZE = 1024;
  localparam int          NW   = SIZE / 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  lsu_state_t state;

  riscv_lsu_if bus();

  riscv_lsu #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- word memory (bench side) ----------------
  logic [31:0] mem [NW];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.data_we_o) mem[bus.data_addr_o[9:2]] <= bus.data_wdata_o;
  end

  assign bus.data_rdata_i = mem[bus.data_addr_o[9:2]];

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]  ref_mem [SIZE];
  // {stall cycles[1:0], fault, write, load data or write word}
  logic [35:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural view: memory is a byte array, an access is legal if its size
  // exists for that direction, it is naturally aligned and it fits the window.
  task automatic model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] data, output logic [35:0] e);
    logic           size_ok;
    int             n;
    int             off;
    int             wb;
    logic [31:0]    val;
    longint unsigned a;
    size_ok = we ? (size inside {3'd0, 3'd1, 3'd2}) : (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 1 << size[1:0];
    a = longint'(addr);
    if (!size_ok || (addr % n) != 0 || a < longint'(BASE) || a >= longint'(BASE) + SIZE) begin
      e = {2'd0, 1'b1, 1'b0, 32'h0};
    end else begin
      off = int'(addr - BASE);
      if (!we) begin
        val = 32'h0;
        for (int i = 0; i < n; i++) val = val | (32'(ref_mem[off + i]) << (8 * i));
        if (!size[2] && n < 4 && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
        e = {2'd1, 1'b0, 1'b0, val};
      end else begin
        for (int i = 0; i < n; i++) ref_mem[off + i] = data[8 * i +: 8];
        wb = off & ~3;
        val = {ref_mem[wb + 3], ref_mem[wb + 2], ref_mem[wb + 1], ref_mem[wb]};
        e = {(n == 4) ? 2'd0 : 2'd1, 1'b0, 1'b1, val};
      end
    end
  endtask

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    int off;
    off = int'(addr - BASE) & ~3;
    pre_idx  = 8'(off >> 2);
    pre_data = word;
    pre_we   = 1'b1;
    for (int i = 0; i < 4; i++) ref_mem[off + i] = word[8 * i +: 8];
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.lsu_req_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] data);
    logic [35:0] e;
    logic        done;
    model(we, size, addr, data, e);
    exp_q.push_back(e);
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = we;
    bus.lsu_size_i = size;
    bus.lsu_addr_i = addr;
    bus.lsu_data_i = data;
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus.lsu_stall_req_o) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: addr %h still stalled after 10 cycles", addr);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    int          cnt;
    logic [35:0] act;
    logic [35:0] e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !bus.lsu_req_i) begin
        cnt = 0;
      end else if (bus.lsu_stall_req_o) begin
        cnt++;
      end else begin
        act = {2'(cnt), bus.lsu_fault_o, bus.data_we_o,
               bus.data_we_o ? bus.data_wdata_o : bus.lsu_data_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_completion: got %h expected no completion", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL completion addr %h: got stalls=%0d fault=%b we=%b data=%h expected stalls=%0d fault=%b we=%b data=%h",
                     bus.lsu_addr_i, act[35:34], act[33], act[32], act[31:0],
                     e[35:34], e[33], e[32], e[31:0]);
          end
        end
        cnt = 0;
      end
      if (bus.data_we_o) begin
        checks++;
        if (!(bus.lsu_req_i && !bus.lsu_stall_req_o) || rst) begin
          errors++;
          $display("FAIL stray_write: got data_we_o=1 expected 0 (addr %h)", bus.data_addr_o);
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  kind;
    logic [31:0] a;
    bus.lsu_req_i  = 1'b0;
    bus.lsu_we_i   = 1'b0;
    bus.lsu_size_i = 3'b000;
    bus.lsu_addr_i = 32'h0;
    bus.lsu_data_i = 32'h0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'(IDLE));
    check("reset_we", 32'(bus.data_we_o), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_stall", 32'(bus.lsu_stall_req_o), 32'h0);
    check("idle_fault", 32'(bus.lsu_fault_o), 32'h0);
    check("idle_data", bus.lsu_data_o, 32'h0);

    for (int i = 0; i < NW; i++) preload(BASE + 32'(4 * i), $urandom());

    // loads with extension
    preload(32'h8800_0010, 32'h8899_AABB);
    do_req(1'b0, LDST_B,  32'h8800_0011, 32'h0);
    do_req(1'b0, LDST_BU, 32'h8800_0011, 32'h0);
    do_req(1'b0, LDST_HU, 32'h8800_0012, 32'h0);
    do_req(1'b0, LDST_H,  32'h8800_0012, 32'h0);
    do_req(1'b0, LDST_W,  32'h8800_0010, 32'h0);
    idle_cycle();

    // word store, then sub-word read-modify-write stores
    do_req(1'b1, LDST_W, 32'h8800_0020, 32'hDEAD_BEEF);
    idle_cycle();
    check("sw_mem", mem[8], 32'hDEAD_BEEF);
    do_req(1'b1, LDST_B, 32'h8800_0022, 32'h0000_0055);
    idle_cycle();
    check("sb_mem", mem[8], 32'hDE55_BEEF);
    preload(32'h8800_0020, 32'hDEAD_BEEF);
    do_req(1'b1, LDST_H, 32'h8800_0020, 32'h0000_1234);
    idle_cycle();
    check("sh_mem", mem[8], 32'hDEAD_1234);

    // faults: misaligned, out of window, undefined size
    do_req(1'b0, LDST_H,  32'h8800_0001, 32'h0);
    do_req(1'b1, LDST_W,  32'h8800_0002, 32'h1111_2222);
    do_req(1'b0, LDST_W,  32'h8800_0400, 32'h0);
    do_req(1'b0, LDST_W,  32'h87FF_FFFC, 32'h0);
    do_req(1'b0, 3'b011,  32'h8800_0010, 32'h0);
    do_req(1'b1, LDST_BU, 32'h8800_0010, 32'h0000_0077);
    do_req(1'b0, LDST_B,  32'h8800_03FF, 32'h0);
    idle_cycle();

    // reset while a sub-word store waits to write
    preload(32'h8800_0030, 32'h1122_3344);
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = 1'b1;
    bus.lsu_size_i = LDST_B;
    bus.lsu_addr_i = 32'h8800_0031;
    bus.lsu_data_i = 32'h0000_00AB;
    @(posedge clk);
    #1;
    check("rmw_state", 32'(state), 32'(STORE_WR));
    #2 rst = 1'b1;
    #1;
    check("rst_we", 32'(bus.data_we_o), 32'h0);
    check("rst_state", 32'(state), 32'(IDLE));
    @(posedge clk);
    #1 bus.lsu_req_i = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mem", mem[12], 32'h1122_3344);

    // core withdraws a load during write-back
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = 1'b0;
    bus.lsu_size_i = LDST_W;
    bus.lsu_addr_i = 32'h8800_0010;
    @(posedge clk);
    #1;
    check("abort_state", 32'(state), 32'(LOAD_WB));
    bus.lsu_req_i = 1'b0;
    #1;
    check("abort_fault", 32'(bus.lsu_fault_o), 32'h0);
    check("abort_stall", 32'(bus.lsu_stall_req_o), 32'h0);
    @(posedge clk);
    #1;
    check("abort_idle", 32'(state), 32'(IDLE));

    // random LW / SB / SW stream, mostly back to back
    for (int i = 0; i < 100; i++) begin
      kind = 3'(i % 3);
      case (kind)
        3'd0: begin
          a = BASE + 32'(4 * $urandom_range(0, NW - 1));
          do_req(1'b0, LDST_W, a, 32'h0);
        end
        3'd1: begin
          a = BASE + 32'($urandom_range(0, SIZE - 1));
          do_req(1'b1, LDST_B, a, $urandom());
        end
        default: begin
          a = BASE + 32'(4 * $urandom_range(0, NW - 1));
          do_req(1'b1, LDST_W, a, $urandom());
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    for (int w = 0; w < NW; w++) begin
      check($sformatf("final_mem[%0d]", w), mem[w],
            {ref_mem[4 * w + 3], ref_mem[4 * w + 2], ref_mem[4 * w + 1], ref_mem[4 * w]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
